// File: rtl/seq_divisor.sv
// Restoring sequential divider, one quotient bit per clock.
// Signed two's-complement operation when DIVISOR_SIGNED_EN is defined.
module seq_divisor #(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             RSTa,
  input  logic             Start,
  input  logic [WIDTH-1:0] Num,
  input  logic [WIDTH-1:0] Den,
  output logic [WIDTH-1:0] Coc,
  output logic [WIDTH-1:0] Res,
  output logic             Done,
  output logic             Busy
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    CALC,
    FIX
  } state_t;

  state_t state;
  state_t nxt;

  logic [WIDTH-1:0] num_q;
  logic [WIDTH-1:0] den_q;
  logic [WIDTH-1:0] dvs;
  logic [WIDTH-1:0] quot;
  logic [WIDTH:0]   rem;
  logic [CW-1:0]    cnt;

  logic             num_neg;
  logic             den_neg;
  logic [WIDTH-1:0] num_mag;
  logic [WIDTH-1:0] den_mag;
  logic [WIDTH:0]   sh;
  logic             ge;
  logic [WIDTH:0]   rem_n;
  logic [WIDTH-1:0] quot_n;
  logic [WIDTH-1:0] coc_fix;
  logic [WIDTH-1:0] res_fix;
  logic             last;

`ifdef DIVISOR_SIGNED_EN
  assign num_neg = num_q[WIDTH-1];
  assign den_neg = den_q[WIDTH-1];
`else
  assign num_neg = 1'b0;
  assign den_neg = 1'b0;
`endif

  assign num_mag = num_neg ? (~num_q + 1'b1) : num_q;
  assign den_mag = den_neg ? (~den_q + 1'b1) : den_q;

  // rem[WIDTH] set means the shifted value already exceeds any divisor
  assign sh     = {rem[WIDTH-1:0], quot[WIDTH-1]};
  assign ge     = rem[WIDTH] | (sh >= {1'b0, dvs});
  assign rem_n  = ge ? (sh - {1'b0, dvs}) : sh;
  assign quot_n = {quot[WIDTH-2:0], ge};
  assign last   = (cnt == '0);

  always_comb begin
    coc_fix = quot_n;
    res_fix = rem_n[WIDTH-1:0];
    if (num_neg ^ den_neg)
      coc_fix = ~quot_n + 1'b1;
    if (num_neg)
      res_fix = ~rem_n[WIDTH-1:0] + 1'b1;
`ifdef DIVISOR_SIGNED_EN
    if (num_q == {1'b1, {(WIDTH-1){1'b0}}} &&
        den_q == {WIDTH{1'b1}}) begin
      coc_fix = {1'b1, {(WIDTH-1){1'b0}}};
      res_fix = '0;
    end
`endif
    if (den_q == '0) begin
      coc_fix = {WIDTH{1'b1}};
      res_fix = num_q;
    end
  end

  always_ff @(posedge CLK) begin
    if (RSTa)
      state <= IDLE;
    else
      state <= nxt;
  end

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE: if (Start) nxt = LOAD;
      LOAD: nxt = CALC;
      CALC: if (last) nxt = FIX;
      FIX:  nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RSTa) begin
      num_q <= '0;
      den_q <= '0;
      dvs   <= '0;
      quot  <= '0;
      rem   <= '0;
      cnt   <= '0;
      Coc   <= '0;
      Res   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (Start) begin
            num_q <= Num;
            den_q <= Den;
          end
        end
        LOAD: begin
          quot <= num_mag;
          dvs  <= den_mag;
          rem  <= '0;
          cnt  <= CW'(WIDTH - 1);
        end
        CALC: begin
          quot <= quot_n;
          rem  <= rem_n;
          cnt  <= cnt - 1'b1;
          // results land on the last iteration so they are valid with Done
          if (last) begin
            Coc <= coc_fix;
            Res <= res_fix;
          end
        end
        default: ;
      endcase
    end
  end

  assign Done = (state == FIX);
  assign Busy = (state != IDLE);

endmodule

// File: tb/tb_seq_divisor.sv
// Directed-vector and random-sweep bench for seq_divisor.
// Works for both the unsigned and DIVISOR_SIGNED_EN builds.
module tb_seq_divisor;

  localparam int W = 32;
  localparam int LAT = W + 2;

  logic         CLK;
  logic         RSTa;
  logic         Start;
  logic [W-1:0] Num;
  logic [W-1:0] Den;
  logic [W-1:0] Coc;
  logic [W-1:0] Res;
  logic         Done;
  logic         Busy;

  int checks;
  int failures;

  seq_divisor #(.WIDTH(W)) dut (
    .CLK  (CLK),
    .RSTa (RSTa),
    .Start(Start),
    .Num  (Num),
    .Den  (Den),
    .Coc  (Coc),
    .Res  (Res),
    .Done (Done),
    .Busy (Busy)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic [W-1:0] num;
    logic [W-1:0] den;
    logic [W-1:0] coc;
    logic [W-1:0] res;
  } vec_t;

  task automatic chk(input string name, input logic [W-1:0] act,
                     input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic void model(input logic [W-1:0] n, input logic [W-1:0] d,
                                output logic [W-1:0] q,
                                output logic [W-1:0] r);
    if (d == '0) begin
      q = '1;
      r = n;
    end else begin
`ifdef DIVISOR_SIGNED_EN
      if (n == 32'h8000_0000 && d == 32'hFFFF_FFFF) begin
        q = 32'h8000_0000;
        r = '0;
      end else begin
        q = $signed(n) / $signed(d);
        r = $signed(n) % $signed(d);
      end
`else
      q = n / d;
      r = n % d;
`endif
    end
  endfunction

  // Called just after a negedge; returns edges from accept to Done.
  task automatic do_div(input logic [W-1:0] n, input logic [W-1:0] d,
                        output int lat, output int busy_err);
    Num = n;
    Den = d;
    Start = 1'b1;
    busy_err = 0;
    @(posedge CLK);
    lat = 1;
    @(negedge CLK);
    Start = 1'b0;
    Num = $urandom;
    Den = $urandom;
    while (!Done && lat < 200) begin
      if (!Busy) busy_err++;
      @(posedge CLK);
      lat++;
      @(negedge CLK);
    end
    if (!Busy) busy_err++;
  endtask

  vec_t vecs[8];
  int   lat;
  int   berr;
  int   n_done;
  int   gap;
  logic [W-1:0] eq;
  logic [W-1:0] er;
  logic [W-1:0] rn;
  logic [W-1:0] rd;

  initial begin
    checks = 0;
    failures = 0;
`ifdef DIVISOR_SIGNED_EN
    vecs[0] = '{32'd100, 32'd7, 32'd14, 32'd2};
    vecs[1] = '{-32'sd100, 32'd7, -32'sd14, -32'sd2};
    vecs[2] = '{32'd100, -32'sd7, -32'sd14, 32'd2};
    vecs[3] = '{32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0};
    vecs[4] = '{32'd12345, 32'd0, 32'hFFFF_FFFF, 32'd12345};
    vecs[5] = '{-32'sd100, -32'sd7, 32'd14, -32'sd2};
    vecs[6] = '{-32'sd7, 32'd0, 32'hFFFF_FFFF, -32'sd7};
    vecs[7] = '{32'd5, 32'd9, 32'd0, 32'd5};
`else
    vecs[0] = '{32'd100, 32'd7, 32'd14, 32'd2};
    vecs[1] = '{32'hFFFF_FFFF, 32'd2, 32'h7FFF_FFFF, 32'd1};
    vecs[2] = '{32'd12345, 32'd0, 32'hFFFF_FFFF, 32'd12345};
    vecs[3] = '{32'd0, 32'd5, 32'd0, 32'd0};
    vecs[4] = '{32'd7, 32'd7, 32'd1, 32'd0};
    vecs[5] = '{32'd5, 32'd9, 32'd0, 32'd5};
    vecs[6] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 32'd0};
    vecs[7] = '{32'h8000_0000, 32'd1, 32'h8000_0000, 32'd0};
`endif

    // reset with Start asserted
    RSTa = 1'b1;
    Start = 1'b1;
    Num = 32'd9;
    Den = 32'd3;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    chk("rst_coc", Coc, '0);
    chk("rst_res", Res, '0);
    chk("rst_done", W'(Done), '0);
    chk("rst_busy", W'(Busy), '0);
    Start = 1'b0;
    RSTa = 1'b0;
    @(negedge CLK);
    chk("rst_idle_busy", W'(Busy), '0);

    // directed table
    foreach (vecs[i]) begin
      do_div(vecs[i].num, vecs[i].den, lat, berr);
      chk($sformatf("v%0d_lat", i), W'(lat), W'(LAT));
      chk($sformatf("v%0d_busy", i), W'(berr), '0);
      chk($sformatf("v%0d_coc", i), Coc, vecs[i].coc);
      chk($sformatf("v%0d_res", i), Res, vecs[i].res);
      @(negedge CLK);
      chk($sformatf("v%0d_pulse", i), W'(Done), '0);
      chk($sformatf("v%0d_hold", i), Coc, vecs[i].coc);
    end

    // mid-run Start with new operands must be ignored
    Num = 32'd50;
    Den = 32'd5;
    Start = 1'b1;
    @(posedge CLK);
    lat = 1;
    @(negedge CLK);
    Start = 1'b0;
    repeat (8) begin
      @(posedge CLK);
      lat++;
      @(negedge CLK);
    end
    Num = 32'd7;
    Den = 32'd1;
    Start = 1'b1;
    @(posedge CLK);
    lat++;
    @(negedge CLK);
    Start = 1'b0;
    while (!Done && lat < 200) begin
      @(posedge CLK);
      lat++;
      @(negedge CLK);
    end
    chk("ign_lat", W'(lat), W'(LAT));
    chk("ign_coc", Coc, 32'd10);
    chk("ign_res", Res, 32'd0);
    @(negedge CLK);
    chk("ign_no_requeue", W'(Busy), '0);

    // Start held high: back-to-back spacing
    Num = 32'd81;
    Den = 32'd9;
    Start = 1'b1;
    n_done = 0;
    gap = 0;
    lat = 0;
    while (n_done < 2 && lat < 300) begin
      @(posedge CLK);
      lat++;
      @(negedge CLK);
      if (n_done == 1) gap++;
      if (Done) n_done++;
    end
    Start = 1'b0;
    chk("b2b_count", W'(n_done), 32'd2);
    chk("b2b_gap", W'(gap), W'(W + 3));
    chk("b2b_coc", Coc, 32'd9);
    while (Busy && lat < 400) begin
      @(posedge CLK);
      lat++;
      @(negedge CLK);
    end

    // abort by reset at clock 10
    Num = 32'd1000;
    Den = 32'd3;
    Start = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    Start = 1'b0;
    repeat (9) @(negedge CLK);
    RSTa = 1'b1;
    @(negedge CLK);
    RSTa = 1'b0;
    chk("abort_coc", Coc, '0);
    chk("abort_res", Res, '0);
    chk("abort_busy", W'(Busy), '0);
    n_done = 0;
    repeat (40) begin
      @(negedge CLK);
      if (Done) n_done++;
    end
    chk("abort_no_done", W'(n_done), '0);

    // random sweep against the reference rules
    for (int k = 0; k < 1000; k++) begin
      rn = $urandom;
      rd = $urandom;
      unique case (k % 8)
        0: rd = '0;
        1: rd = W'($urandom_range(1, 15));
        2: rd = rd >> $urandom_range(1, W - 1);
        3: rd = '1;
        default: ;
      endcase
      if (k == 5) rn = 32'h8000_0000;
      model(rn, rd, eq, er);
      do_div(rn, rd, lat, berr);
      checks++;
      if (Coc !== eq || Res !== er || lat != LAT || berr != 0) begin
        failures++;
        $display("FAIL rnd%0d: %h/%h got q=%h r=%h lat=%0d need q=%h r=%h lat=%0d",
                 k, rn, rd, Coc, Res, lat, eq, er, LAT);
      end
      @(negedge CLK);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seq_divisor.md
Name: seq_divisor

Overview:
- Multi-cycle integer divider (restoring, one quotient bit per clock) producing quotient and remainder of a dividend/divisor pair.
- Instantiated inside the top-level DUV wrapper as the divider instance.
- Driven through the shared test interface by the stimulus program.
- Handshake: Start pulse in, one-cycle Done pulse out.

Parameters:
- WIDTH, 32, bit width of dividend, divisor, quotient and remainder (supported range: WIDTH >= 4).

Ports:
- CLK  input  1  system clock; all state updates on the rising edge.
- RSTa  input  1  reset; synchronous and active-high.
- Start  input  1  request to start a division; sampled only in IDLE.
- Num  input  WIDTH  dividend; captured on the accepting edge.
- Den  input  WIDTH  divisor; captured on the accepting edge.
- Coc  output  WIDTH  quotient (registered).
- Res  output  WIDTH  remainder (registered).
- Done  output  1  one-cycle pulse: Coc/Res are valid and updated.
- Busy  output  1  high from the accepting edge until Done inclusive.

Behaviour:
- Reset (RSTa=1 at a rising edge): state=IDLE; Coc=0, Res=0, Done=0, Busy=0; internal accumulators cleared. Reset overrides Start.
- Reset mid-operation aborts the division. No Done is produced and outputs read 0 on the following cycle.
- States and transitions:
  - IDLE: wait for Start.
  - LOAD: capture operands and take magnitudes per sign mode.
  - CALC: WIDTH iterations.
  - FIX: apply signs, register outputs, Done=1; then return to IDLE.
- Start=1 in IDLE at edge E0 -> LOAD. Internal operands latched at E0.
- Edge E1: LOAD -> CALC with counter=WIDTH-1.
- Each CALC edge:
  - shift {rem,quot} left 1, bringing in the dividend MSB.
  - if rem >= |Den|, subtract |Den| and set quot bit0=1.
  - decrement the counter.
- After WIDTH CALC edges -> FIX. Done=1 and Coc/Res updated in the cycle after edge E0+WIDTH+1, i.e. latency WIDTH+2 clocks from the accepting edge.
- Next edge FIX -> IDLE, Done=0.
- Start and operand changes while Busy=1 are ignored; no queueing.
- Start held high continuously: a new division is accepted on the first edge in IDLE.
  - Back-to-back throughput is one result per WIDTH+3 clocks.
- Coc/Res hold their last values between operations; they change only in FIX or on reset.
- Signed rules (when signed mode is active): quotient truncates toward zero; remainder takes the sign of the dividend; |Res| < |Den|.
- Divide by zero (Den=0): Coc = all ones, Res = Num. Same latency, Done still pulses.
- Signed overflow (Num = most negative, Den = -1): Coc = most negative value, Res = 0.
- Internal remainder register is WIDTH+1 bits to avoid compare overflow. All outputs are WIDTH bits.

Optional Feature:
- Macro DIVISOR_SIGNED_EN.
- Defined: operands and results are two's-complement signed, following the signed, divide-by-zero and overflow rules above.
- Undefined: purely unsigned division. No sign handling; the overflow rule does not apply; divide by zero still gives Coc = all ones, Res = Num.
- Latency is identical in both builds.

Test Plan:
- Reset: assert RSTa for 2 clocks with Start=1 -> Coc=0, Res=0, Done=0, Busy=0. Start not accepted while RSTa=1.
- Basic: Num=100, Den=7, Start for 1 clock -> Done pulses exactly once 34 clocks after the accepting edge (WIDTH=32); Coc=14, Res=2.
- Signed (DIVISOR_SIGNED_EN): Num=-100, Den=7 -> Coc=-14, Res=-2. Num=100, Den=-7 -> Coc=-14, Res=2. Num=0x80000000, Den=-1 -> Coc=0x80000000, Res=0.
- Unsigned build: Num=0xFFFFFFFF, Den=2 -> Coc=0x7FFFFFFF, Res=1.
- Divide by zero: Num=12345, Den=0 -> Coc=0xFFFFFFFF, Res=12345, Done after 34 clocks.
- Busy/abort:
  - Start with Num=50, Den=5; pulse Start with other operands mid-run -> ignored, result Coc=10, Res=0.
  - New division, then RSTa=1 at clock 10 -> no Done, outputs 0.
  - Random sweep of 1000 operand pairs checked against the reference rules.
